btn_event_gen: RTL and testbench

- Turns one raw push-button level into clean single-clock event pulses: press, release, long-press and auto-repeat. It is the consumer side of the button path.
- Sits between a board button pin and stopwatch control logic such as pause, reset and adjust.
- Runs on the main clock and samples on a one-cycle tick enable from the clock-divider block, so control logic never needs a second clock domain.

---
 rtl/btn_event_gen.sv | 153 +++++++++++++++
 tb/tb_btn_event_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/btn_event_gen.sv
// btn_event_gen: raw push-button level -> debounced level plus single-cycle
// press / release / long-press / auto-repeat pulses, sampled on a tick enable.
// Optional auto-repeat is compiled only when BTN_EVENT_REPEAT_EN is defined;
// otherwise repeat_pulse is tied low and LONG simply waits for release.
module btn_event_gen #(
  parameter int CNT_W        = 8,
  parameter int DB_TICKS     = 4,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  typedef enum logic [1:0] {IDLE, DOWN, LONG} state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_TICKS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`ifdef BTN_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
`endif

  logic             sync1, sync2;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  state_t           state, state_nxt;
  logic             press_nxt, release_nxt, long_nxt;
`ifdef BTN_EVENT_REPEAT_EN
  logic             repeat_nxt;
`endif

  // Two-flop synchronizer, runs every clk so metastability settles regardless of tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a level change after DB_TICKS consecutive mismatching ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (tick) begin
      if (sync2 != btn_level) begin
        if (db_cnt == DB_LAST) begin
          btn_level <= ~btn_level;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // State, hold counter and registered pulses; pulses default low so they last one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_nxt;
      hold_cnt      <= hold_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
    end
  end

`ifdef BTN_EVENT_REPEAT_EN
  // Registered auto-repeat pulse.
  always_ff @(posedge clk) begin
    if (rst) repeat_pulse <= 1'b0;
    else     repeat_pulse <= repeat_nxt;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

  // Next-state logic; a falling level is checked first so release beats long/repeat.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
    repeat_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (btn_level) begin
          state_nxt = DOWN;
          hold_nxt  = '0;
          press_nxt = 1'b1;
        end
      end
      DOWN: begin
        if (!btn_level) begin
          state_nxt   = IDLE;
          hold_nxt    = '0;
          release_nxt = 1'b1;
        end else if (tick) begin
          if (hold_cnt == LONG_LAST) begin
            state_nxt = LONG;
            hold_nxt  = '0;
            long_nxt  = 1'b1;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
      end
      LONG: begin
        if (!btn_level) begin
          state_nxt   = IDLE;
          hold_nxt    = '0;
          release_nxt = 1'b1;
        end
`ifdef BTN_EVENT_REPEAT_EN
        else if (tick) begin
          if (hold_cnt == REP_LAST) begin
            hold_nxt   = '0;
            repeat_nxt = 1'b1;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench for btn_event_gen: a tick-level event model predicts each
// pulse (kind and clk index), a negedge monitor pops and compares.
module tb_btn_event_gen;
  localparam int DB = 4;
  localparam int LG = 10;
  localparam int RP = 3;
`ifdef BTN_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

  btn_event_gen #(.CNT_W(8), .DB_TICKS(DB), .LONG_TICKS(LG), .REPEAT_TICKS(RP)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_raw(btn_raw),
    .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int cyc;} ev_t;
  ev_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tmode = 0;
  int seen[4] = '{0, 0, 0, 0};
  string kname[4] = '{"press", "release", "long", "repeat"};

  // reference model state: raw-delay line, debounced level, hold tracking
  bit m_s1, m_s2, m_lvl, m_held;
  int m_run, m_ticks;

  // Event model: what the button means, evaluated at one clk edge.
  task automatic model();
    bit s2_old, lvl_old;
    ev_t e;
    cyc++;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_held = 0; m_run = 0; m_ticks = 0;
    end else begin
      s2_old = m_s2; lvl_old = m_lvl;
      m_s2 = m_s1; m_s1 = btn_raw;
      if (tick) begin
        if (s2_old != lvl_old) begin
          m_run++;
          if (m_run == DB) begin m_lvl = !m_lvl; m_run = 0; end
        end else m_run = 0;
      end
      e.cyc = cyc;
      if (!m_held && lvl_old) begin
        m_held = 1; m_ticks = 0; e.kind = 0; q.push_back(e);
      end else if (m_held && !lvl_old) begin
        m_held = 0; e.kind = 1; q.push_back(e);
      end else if (m_held && tick) begin
        m_ticks++;
        if (m_ticks == LG) begin e.kind = 2; q.push_back(e); end
        else if (REP_EN && m_ticks > LG && (m_ticks - LG) % RP == 0) begin
          e.kind = 3; q.push_back(e);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    if (tmode == 0) tick = (cyc % 4 == 3);
    else            tick = ($urandom % 3 == 0);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: level every cycle, pulses popped from the scoreboard.
  initial begin
    int n, kind;
    ev_t e;
    forever begin
      @(negedge clk);
      n = int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse);
      kind = press_pulse ? 0 : release_pulse ? 1 : long_pulse ? 2 : 3;
      checks++;
      if (btn_level !== m_lvl) begin
        errors++;
        $display("FAIL level cyc=%0d got=%b exp=%b", cyc, btn_level, m_lvl);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL missing_%s exp_cyc=%0d got=none", kname[e.kind], e.cyc);
      end
      if (n > 1) begin
        checks++; errors++;
        $display("FAIL exclusive cyc=%0d got=%0d pulses exp=1", cyc, n);
      end
      if (n >= 1) begin
        seen[kind]++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_%s cyc=%0d got=pulse exp=none", kname[kind], cyc);
        end else begin
          e = q.pop_front();
          if (e.kind != kind || e.cyc != cyc) begin
            errors++;
            $display("FAIL pulse got=%s@%0d exp=%s@%0d", kname[kind], cyc, kname[e.kind], e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    int s0[4];
    int guard;
    // reset then idle
    rst = 1; btn_raw = 0;
    wait_cyc(3);
    rst = 0;
    wait_cyc(50);
    @(negedge clk);
    check("idle_outputs", {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);

    // long hold with repeats, then release
    s0 = seen;
    btn_raw = 1;
    guard = 0;
    while (!(m_held && m_ticks >= 20) && guard < 400) begin step(); guard++; end
    check("hold_reached", int'(guard < 400), 1);
    btn_raw = 0;
    wait_cyc(60);
    check("hold_press_cnt", seen[0] - s0[0], 1);
    check("hold_release_cnt", seen[1] - s0[1], 1);
    check("hold_long_cnt", seen[2] - s0[2], 1);
    if (REP_EN) check("hold_repeat_ge3", int'(seen[3] - s0[3] >= 3), 1);
    else        check("hold_repeat_none", seen[3] - s0[3], 0);

    // glitch of two ticks: no acceptance
    s0 = seen;
    btn_raw = 1; wait_cyc(8);
    btn_raw = 0; wait_cyc(60);
    check("glitch_pulses", (seen[0] + seen[1] + seen[2] + seen[3]) - (s0[0] + s0[1] + s0[2] + s0[3]), 0);

    // reset while in LONG: no release, then a clean re-press
    s0 = seen;
    btn_raw = 1;
    guard = 0;
    while (!(m_held && m_ticks > LG) && guard < 400) begin step(); guard++; end
    rst = 1; btn_raw = 0; step();
    rst = 0; step();
    check("rst_level", int'(btn_level), 0);
    wait_cyc(40);
    check("rst_no_release", seen[1] - s0[1], 0);
    btn_raw = 1; wait_cyc(60);
    check("repress_cnt", seen[0] - s0[0], 2);
    btn_raw = 0; wait_cyc(60);

    // randomized segments, regular and irregular tick spacing
    for (int s = 0; s < 60; s++) begin
      tmode = (s >= 30) ? int'($urandom % 2) : 0;
      if ($urandom % 20 == 0) begin rst = 1; step(); rst = 0; end
      btn_raw = $urandom % 2;
      wait_cyc($urandom_range(1, 150));
    end
    tmode = 0;
    btn_raw = 0;
    wait_cyc(200);
    @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
